mole_round_ctrl: RTL and testbench
==================================

// Module: mole_round_ctrl
// PURPOSE
//  Game core downstream of difficulty selection. Consumes start_game and the one-hot difficulty byte.
//  Runs one timed round: one mole at a time on mole_led, lit at an LFSR position.
//  Mole lifetime shrinks with level; debounced whack switches are scored as hit/wrong/escape.
//  Asserts game_over when the round timer expires; held until rst.
// PARAMETERS
//  CLK_HZ      100_000_000  clk cycles per 1 s timer tick
//  GAME_SEC    60           round length in seconds (1..127)
//  MOLE_T_L1   100_000_000  mole lifetime in cycles at level 1
//  MOLE_T_STEP 10_000_000   lifetime reduction per level; level n = MOLE_T_L1-(n-1)*MOLE_T_STEP
//  GAP_TICKS   20_000_000   dark cycles between moles
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-high reset
//  start_game  in   1  level from upstream, high = selection done; round starts on its rising edge
//  difficulty  in   8  one-hot level, bit k = level k+1
//  whack       in   8  debounced player switches, async to clk
//  mole_led    out  8  one-hot mole position, 0 when dark
//  score       out  8  hit count, saturating at 255
//  miss_cnt    out  8  wrong whacks + escapes, saturating at 255
//  time_left   out  7  seconds remaining
//  level       out  4  decoded level 1..8, 0 in IDLE
//  game_over   out  1  sticky end-of-round flag
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; LFSR = 16'hACE1; counters cleared. rst mid-round aborts to IDLE at once.
//  whack: 2-FF synchroniser + rising-edge register; edge pulse 3 cycles after pin change; 1-cycle pulse per bit.
//  States: IDLE -> ARM -> SHOW <-> GAP -> OVER.
//   IDLE: wait for start_game rising edge (registered compare); start_game already high at rst release is not an edge.
//   ARM (1 cycle): latch level from difficulty; invalid (zero or multi-hot) -> level 1.
//    Also: time_left=GAME_SEC, score=miss_cnt=0, start 1 s prescaler; -> SHOW.
//   SHOW: mole_led = 1<<pos; lifetime counter runs from 0.
//    On entry, pos = lfsr[2:0]; if pos equals the previous pos, use (pos+1) mod 8.
//    Whack edge on lit bit: score+1, -> GAP next cycle, mole_led=0 in same cycle as score update.
//    Edges on unlit bits only: miss_cnt+1 (once per cycle, regardless of bit count); stay in SHOW.
//    Lit and unlit edges in the same cycle: hit only, unlit ignored.
//    Lifetime reaches level limit with no hit: escape, miss_cnt+1, -> GAP.
//   GAP: mole_led=0 for GAP_TICKS cycles; whack edges ignored; -> SHOW.
//   OVER: mole_led=0, game_over=1. score, miss_cnt and time_left=0 frozen. Leave only via rst.
//  Timer: prescaler wraps at CLK_HZ-1, time_left-1.
//   time_left reaching 0 in SHOW or GAP -> OVER next cycle; this overrides a same-cycle hit/escape, which is not counted.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle from reset.
//  Widths: lifetime/gap/prescaler counters 27 bits; level limit computed in ARM and held in a register.
// CONFIGURATION
//  MISS_PENALTY_EN defined: each wrong-whack cycle also decrements score, saturating at 0; escapes do not.
//   Same-cycle hit+wrong still = hit only.
//  Undefined: wrong whacks only increment miss_cnt; score never decreases.
// STRUCTURE
//  Package whack_pkg: state encodings, LFSR seed/taps, level count (8), 8-bit saturation limit.
//  Sub-module mole_lfsr: free-running 16-bit LFSR, output lfsr[15:0]; instantiated once.
//  Synchroniser, edge detect, FSM, timers and counters live in mole_round_ctrl.
// TESTING  (CLK_HZ=1000, GAME_SEC=3, MOLE_T_L1=200, MOLE_T_STEP=20, GAP_TICKS=50)
//  1 difficulty=8'h04, start_game 0->1:
//    -> level=3 after 1 cycle; mole_led one-hot after 2; lifetime 160 cycles.
//  2 Whack lit bit:
//    -> score=1 and mole_led=0 exactly 4 cycles after pin edge; mole relights after 50 dark cycles.
//  3 No whack:
//    -> miss_cnt+1 at cycle 160 of SHOW; relit pos differs from previous pos.
//  4 Lit and unlit bits pressed in the same cycle:
//    -> score+1, miss_cnt unchanged; with MISS_PENALTY_EN, wrong-only press at score=0 leaves score=0.
//  5 Run 3000 cycles:
//    -> time_left 3,2,1,0; game_over=1; mole_led=0; further whacks change nothing.
//    -> start_game toggle ignored.
//  6 difficulty=8'h05, then rst pulse mid-SHOW:
//    -> level=1 (limit 200); rst clears all outputs immediately.
//    -> start_game held high through rst release does not restart.

Source files
------------

// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Shared definitions for the whack-a-mole round controller:
//   - state_t     : round FSM states
//   - LFSR_SEED   : reset value of the mole position LFSR
//   - LFSR_TAPS   : feedback mask for taps 16,14,13,11 (bit n-1 for tap n)
//   - NUM_LEVELS  : number of difficulty levels (one per difficulty bit)
//   - SAT8_MAX    : saturation limit of the 8-bit score / miss counters
//   - decode_level, sat_add8, sat_dec8 : small helpers used by the FSM
// -----------------------------------------------------------------------------
package whack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SHOW,
    ST_GAP,
    ST_OVER
  } state_t;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int unsigned NUM_LEVELS = 8;
  localparam logic [7:0]  SAT8_MAX   = 8'hFF;

  // One-hot difficulty byte to level 1..8; zero or multi-hot falls back to 1.
  function automatic logic [3:0] decode_level(input logic [7:0] onehot);
    logic [3:0]  lvl;
    int unsigned hot;
    lvl = 4'd1;
    hot = 0;
    for (int unsigned k = 0; k < NUM_LEVELS; k++) begin
      if (onehot[k]) begin
        hot = hot + 1;
        lvl = 4'(k + 1);
      end
    end
    return (hot == 1) ? lvl : 4'd1;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, inc};
    return s[8] ? SAT8_MAX : s[7:0];
  endfunction

  function automatic logic [7:0] sat_dec8(input logic [7:0] a);
    return (a == '0) ? '0 : a - 8'd1;
  endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// mole_round_ctrl_if
// Player/board side signals of the round controller.
//   start_game  upstream "selection done" level
//   difficulty  one-hot level byte
//   whack       debounced player switches (asynchronous to clk)
//   mole_led    one-hot lit mole, 0 when dark
//   score       hit count (saturating)
//   miss_cnt    wrong whacks + escapes (saturating)
//   time_left   seconds remaining in the round
//   level       decoded level 1..8, 0 before a round starts
//   game_over   sticky end-of-round flag
// modport master : the driver of the game inputs (selection logic / board)
// modport slave  : the round controller
// -----------------------------------------------------------------------------
interface mole_round_ctrl_if;
  logic       start_game;
  logic [7:0] difficulty;
  logic [7:0] whack;
  logic [7:0] mole_led;
  logic [7:0] score;
  logic [7:0] miss_cnt;
  logic [6:0] time_left;
  logic [3:0] level;
  logic       game_over;

  modport master (
    output start_game, difficulty, whack,
    input  mole_led, score, miss_cnt, time_left, level, game_over
  );

  modport slave (
    input  start_game, difficulty, whack,
    output mole_led, score, miss_cnt, time_left, level, game_over
  );
endinterface

// File: rtl/mole_lfsr.sv
// -----------------------------------------------------------------------------
// mole_lfsr
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every cycle
// from reset; seeded with LFSR_SEED.
//   clk     system clock
//   rst     asynchronous, active-high reset
//   lfsr_o  current LFSR state
// -----------------------------------------------------------------------------
module mole_lfsr
  import whack_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mole_round_ctrl.sv
// -----------------------------------------------------------------------------
// mole_round_ctrl
// Runs one timed whack-a-mole round: one mole lit at a time at an LFSR-chosen
// position, mole lifetime shrinking with level, hits/wrong whacks/escapes
// scored, sticky game_over when the round timer runs out (cleared only by rst).
// Ports:
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  mole_round_ctrl_if.slave (start_game, difficulty, whack in;
//        mole_led, score, miss_cnt, time_left, level, game_over out)
// Parameters: CLK_HZ (cycles per 1 s tick), GAME_SEC, MOLE_T_L1,
//   MOLE_T_STEP, GAP_TICKS.
// Build option: define MISS_PENALTY_EN to make every wrong-whack cycle also
//   decrement score (saturating at 0); escapes never touch score.
// -----------------------------------------------------------------------------
module mole_round_ctrl
  import whack_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned GAME_SEC    = 60,
  parameter int unsigned MOLE_T_L1   = 100_000_000,
  parameter int unsigned MOLE_T_STEP = 10_000_000,
  parameter int unsigned GAP_TICKS   = 20_000_000
) (
  input  logic             clk,
  input  logic             rst,
  mole_round_ctrl_if.slave bus
);

  localparam logic [26:0] PRESC_LAST = 27'(CLK_HZ - 1);
  localparam logic [26:0] GAP_LAST   = 27'(GAP_TICKS - 1);
  localparam logic [26:0] LIFE_L1    = 27'(MOLE_T_L1);
  localparam logic [26:0] LIFE_STEP  = 27'(MOLE_T_STEP);
  localparam logic [6:0]  ROUND_SEC  = 7'(GAME_SEC);

  state_t      state_q, state_d;
  logic [3:0]  level_q, level_d;
  logic [26:0] limit_q, limit_d;
  logic [26:0] life_q,  life_d;
  logic [26:0] gap_q,   gap_d;
  logic [26:0] presc_q, presc_d;
  logic [6:0]  time_q,  time_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  miss_q,  miss_d;
  logic [2:0]  pos_q,   pos_d;

  logic        start_q;
  logic [7:0]  wsync1_q, wsync2_q, wprev_q, wedge_q;

  logic [15:0] lfsr;
  logic [12:0] lfsr_unused;
  logic [2:0]  next_pos;
  logic [7:0]  lit;
  logic        start_rise;
  logic        hit;
  logic        wrong;
  logic        escape;

  mole_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr)
  );

  assign lfsr_unused = lfsr[15:3];

  // Never relight the same hole twice in a row.
  assign next_pos   = (lfsr[2:0] == pos_q) ? pos_q + 3'd1 : lfsr[2:0];
  assign lit        = (state_q == ST_SHOW) ? (8'd1 << pos_q) : '0;
  assign start_rise = bus.start_game & ~start_q;
  assign hit        = |(wedge_q & lit);
  assign wrong      = |(wedge_q & ~lit);
  assign escape     = (life_q == limit_q - 27'd1);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    limit_d = limit_q;
    life_d  = life_q;
    gap_d   = gap_q;
    presc_d = presc_q;
    time_d  = time_q;
    score_d = score_q;
    miss_d  = miss_q;
    pos_d   = pos_q;

    // Round timer; stops once it reaches zero.
    if ((state_q inside {ST_ARM, ST_SHOW, ST_GAP}) && (time_q != '0)) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        time_d  = time_q - 7'd1;
      end else begin
        presc_d = presc_q + 27'd1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_ARM;
          level_d = decode_level(bus.difficulty);
          time_d  = ROUND_SEC;
          score_d = '0;
          miss_d  = '0;
          presc_d = '0;
        end
      end

      ST_ARM: begin
        state_d = ST_SHOW;
        limit_d = LIFE_L1 - (27'(level_q) - 27'd1) * LIFE_STEP;
        life_d  = '0;
        pos_d   = next_pos;
      end

      // Timer expiry wins over anything else this cycle: the hit/escape is
      // simply not counted.
      ST_SHOW: begin
        if (time_q == '0) begin
          state_d = ST_OVER;
        end else if (hit) begin
          score_d = sat_add8(score_q, 2'd1);
          state_d = ST_GAP;
          gap_d   = '0;
        end else begin
          miss_d = sat_add8(miss_q, {1'b0, wrong} + {1'b0, escape});
`ifdef MISS_PENALTY_EN
          if (wrong) begin
            score_d = sat_dec8(score_q);
          end
`else
`endif
          if (escape) begin
            state_d = ST_GAP;
            gap_d   = '0;
          end else begin
            life_d = life_q + 27'd1;
          end
        end
      end

      ST_GAP: begin
        if (time_q == '0) begin
          state_d = ST_OVER;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_SHOW;
          life_d  = '0;
          pos_d   = next_pos;
        end else begin
          gap_d = gap_q + 27'd1;
        end
      end

      ST_OVER: begin
        state_d = ST_OVER;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      limit_q  <= '0;
      life_q   <= '0;
      gap_q    <= '0;
      presc_q  <= '0;
      time_q   <= '0;
      score_q  <= '0;
      miss_q   <= '0;
      pos_q    <= '0;
      // Starts high so a start_game already high at reset release is no edge.
      start_q  <= 1'b1;
      wsync1_q <= '0;
      wsync2_q <= '0;
      wprev_q  <= '0;
      wedge_q  <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      limit_q  <= limit_d;
      life_q   <= life_d;
      gap_q    <= gap_d;
      presc_q  <= presc_d;
      time_q   <= time_d;
      score_q  <= score_d;
      miss_q   <= miss_d;
      pos_q    <= pos_d;
      start_q  <= bus.start_game;
      wsync1_q <= bus.whack;
      wsync2_q <= wsync1_q;
      wprev_q  <= wsync2_q;
      wedge_q  <= wsync2_q & ~wprev_q;
    end
  end

  assign bus.mole_led  = lit;
  assign bus.score     = score_q;
  assign bus.miss_cnt  = miss_q;
  assign bus.time_left = time_q;
  assign bus.level     = level_q;
  assign bus.game_over = (state_q == ST_OVER);

endmodule

// File: tb/tb_mole_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mole_round_ctrl
// Bench for mole_round_ctrl with small timing parameters. A behavioural round
// model (phase + remaining-time counters, elapsed-cycle timer arithmetic) is
// compared against the outputs every falling edge; directed literal checks pin
// the key latencies and boundary cases.
// -----------------------------------------------------------------------------
module tb_mole_round_ctrl;

  localparam int CLK_HZ      = 1000;
  localparam int GAME_SEC    = 3;
  localparam int MOLE_T_L1   = 200;
  localparam int MOLE_T_STEP = 20;
  localparam int GAP_TICKS   = 50;

  typedef enum int {P_IDLE, P_ARM, P_SHOW, P_GAP, P_OVER} phase_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  mole_round_ctrl_if bus ();

  mole_round_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .GAME_SEC    (GAME_SEC),
    .MOLE_T_L1   (MOLE_T_L1),
    .MOLE_T_STEP (MOLE_T_STEP),
    .GAP_TICKS   (GAP_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state
  phase_t     m_phase      = P_IDLE;
  int         m_level      = 0;
  int         m_score      = 0;
  int         m_miss       = 0;
  int         m_time       = 0;
  int         m_elapsed    = 0;
  int         m_life_left  = 0;
  int         m_gap_left   = 0;
  logic [7:0] m_pos        = '0;
  logic [7:0] m_prev_pos   = '0;
  bit         m_pos_known  = 0;
  bit         m_prev_valid = 0;
  bit         m_start_prev = 1;
  logic [7:0] m_hist [4]   = '{default: '0};

  task automatic check(input string name, input int got, input int exp);
    n_chk = n_chk + 1;
    if (got != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int model_limit(input int lvl);
    return MOLE_T_L1 - (lvl - 1) * MOLE_T_STEP;
  endfunction

  function automatic int model_decode(input logic [7:0] d);
    if ($countones(d) != 1) return 1;
    return $clog2(d) + 1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_level = 0; m_score = 0; m_miss = 0; m_time = 0;
    m_elapsed = 0; m_life_left = 0; m_gap_left = 0; m_pos = '0;
    m_prev_pos = '0; m_pos_known = 0; m_prev_valid = 0; m_start_prev = 1;
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
  endtask

  task automatic model_step();
    logic [7:0] pulse;
    int         t0;
    int         wrong;
    int         esc;
    if (rst) begin
      model_reset();
      return;
    end
    // A pin rise is acted on at the 4th clock edge after it is first sampled.
    pulse = m_hist[2] & ~m_hist[3];
    m_hist[3] = m_hist[2];
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = bus.whack;
    t0 = m_time;
    if (m_phase inside {P_ARM, P_SHOW, P_GAP}) begin
      m_elapsed = m_elapsed + 1;
      m_time = (m_elapsed / CLK_HZ >= GAME_SEC) ? 0 : GAME_SEC - m_elapsed / CLK_HZ;
    end
    case (m_phase)
      P_IDLE: begin
        if (bus.start_game && !m_start_prev) begin
          m_phase = P_ARM; m_level = model_decode(bus.difficulty);
          m_time = GAME_SEC; m_score = 0; m_miss = 0; m_elapsed = 0;
        end
      end
      P_ARM: begin
        m_phase = P_SHOW; m_life_left = model_limit(m_level); m_pos_known = 0;
      end
      P_SHOW: begin
        if (t0 == 0) begin
          m_phase = P_OVER;
        end else if ((pulse & m_pos) != 0) begin
          m_score = (m_score < 255) ? m_score + 1 : 255;
          m_phase = P_GAP; m_gap_left = GAP_TICKS;
          m_prev_pos = m_pos; m_prev_valid = 1;
        end else begin
          wrong = (pulse != 0) ? 1 : 0;
          m_life_left = m_life_left - 1;
          esc = (m_life_left == 0) ? 1 : 0;
          m_miss = (m_miss + wrong + esc > 255) ? 255 : m_miss + wrong + esc;
`ifdef MISS_PENALTY_EN
          if (wrong != 0 && m_score > 0) m_score = m_score - 1;
`endif
          if (esc != 0) begin
            m_phase = P_GAP; m_gap_left = GAP_TICKS;
            m_prev_pos = m_pos; m_prev_valid = 1;
          end
        end
      end
      P_GAP: begin
        if (t0 == 0) begin
          m_phase = P_OVER;
        end else begin
          m_gap_left = m_gap_left - 1;
          if (m_gap_left == 0) begin
            m_phase = P_SHOW; m_life_left = model_limit(m_level); m_pos_known = 0;
          end
        end
      end
      default: ;
    endcase
    m_start_prev = bus.start_game;
  endtask

  task automatic compare_cycle();
    check("score", bus.score, m_score);
    check("miss_cnt", bus.miss_cnt, m_miss);
    check("time_left", bus.time_left, m_time);
    check("level", bus.level, m_level);
    check("game_over", bus.game_over, (m_phase == P_OVER) ? 1 : 0);
    if (m_phase == P_SHOW) begin
      if (!m_pos_known) begin
        // Position is random; only its shape and its change are predictable.
        check("mole_onehot", $countones(bus.mole_led), 1);
        if (m_prev_valid) check("mole_moved", (bus.mole_led != m_prev_pos) ? 1 : 0, 1);
        m_pos = bus.mole_led;
        m_pos_known = 1;
      end else begin
        check("mole_pos", bus.mole_led, m_pos);
      end
    end else begin
      check("mole_dark", bus.mole_led, 0);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mole"}, bus.mole_led, 0);
    check({tag, "_score"}, bus.score, 0);
    check({tag, "_miss"}, bus.miss_cnt, 0);
    check({tag, "_time"}, bus.time_left, 0);
    check({tag, "_level"}, bus.level, 0);
    check({tag, "_over"}, bus.game_over, 0);
  endtask

  initial begin
    logic [7:0] lit_now;
    logic [7:0] prev_lit;
    logic [7:0] other;
    int         seen[$];

    bus.start_game = 1'b0;
    bus.difficulty = '0;
    bus.whack      = '0;

    fork
      forever begin
        @(posedge clk or posedge rst);
        model_step();
      end
      forever begin
        @(negedge clk);
        if (!rst) compare_cycle();
      end
      begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before 2 ms");
        $fatal(1, "bench timeout");
      end
    join_none

    // Reset state
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // 1: level 3 one cycle after start, mole one cycle later
    bus.difficulty = 8'h04;
    bus.start_game = 1'b1;
    tick(1);
    check("t1_level", bus.level, 3);
    check("t1_dark_in_arm", bus.mole_led, 0);
    tick(1);
    check("t1_onehot", $countones(bus.mole_led), 1);
    check("t1_time", bus.time_left, 3);

    // 2: hit the lit mole; result lands exactly 4 cycles after the pin edge
    lit_now = bus.mole_led;
    bus.whack = lit_now;
    tick(3);
    check("t2_score_early", bus.score, 0);
    check("t2_still_lit", bus.mole_led, lit_now);
    tick(1);
    check("t2_score", bus.score, 1);
    check("t2_dark", bus.mole_led, 0);
    bus.whack = '0;
    tick(49);
    check("t2_gap_dark", bus.mole_led, 0);
    tick(1);
    check("t2_relit", $countones(bus.mole_led), 1);

    // 3: no whack -> escape after 160 lit cycles at level 3
    prev_lit = bus.mole_led;
    tick(159);
    check("t3_lit_159", bus.mole_led, prev_lit);
    check("t3_miss_early", bus.miss_cnt, 0);
    tick(1);
    check("t3_miss", bus.miss_cnt, 1);
    check("t3_dark", bus.mole_led, 0);
    tick(50);
    check("t3_relit", $countones(bus.mole_led), 1);
    check("t3_moved", (bus.mole_led != prev_lit) ? 1 : 0, 1);

    // 4: lit + unlit together -> hit only; then unlit only -> wrong whack
    lit_now = bus.mole_led;
    other = {lit_now[6:0], lit_now[7]};
    bus.whack = lit_now | other;
    tick(4);
    check("t4_score", bus.score, 2);
    check("t4_miss", bus.miss_cnt, 1);
    bus.whack = '0;
    tick(50);
    check("t4_relit", $countones(bus.mole_led), 1);
    lit_now = bus.mole_led;
    other = {lit_now[6:0], lit_now[7]};
    bus.whack = other;
    tick(4);
    check("t4_wrong_miss", bus.miss_cnt, 2);
`ifdef MISS_PENALTY_EN
    check("t4_wrong_score", bus.score, 1);
`else
    check("t4_wrong_score", bus.score, 2);
`endif
    check("t4_still_lit", bus.mole_led, lit_now);
    bus.whack = '0;

    // 5: run to the end of the round
    seen.push_back(int'(bus.time_left));
    for (int i = 0; i < 5000 && !bus.game_over; i++) begin
      tick(1);
      if (int'(bus.time_left) != seen[$]) seen.push_back(int'(bus.time_left));
    end
    check("t5_over", bus.game_over, 1);
    check("t5_tl_steps", seen.size(), 4);
    for (int i = 0; i < seen.size() && i < 4; i++) check("t5_tl_value", seen[i], 3 - i);
    bus.whack = 8'hFF;
    tick(5);
    bus.whack = '0;
    bus.start_game = 1'b0;
    tick(3);
    bus.start_game = 1'b1;
    tick(5);
    check("t5_over_held", bus.game_over, 1);
    check("t5_dark", bus.mole_led, 0);
    check("t5_time_zero", bus.time_left, 0);
    check("t5_level_kept", bus.level, 3);

    // 6: multi-hot difficulty -> level 1, then reset mid-SHOW
    rst = 1'b1;
    bus.start_game = 1'b0;
    tick(2);
    rst = 1'b0;
    bus.difficulty = 8'h05;
    tick(2);
    bus.start_game = 1'b1;
    tick(1);
    check("t6_level", bus.level, 1);
    tick(1);
    check("t6_onehot", $countones(bus.mole_led), 1);
    lit_now = bus.mole_led;
    tick(199);
    check("t6_lit_200", bus.mole_led, lit_now);
    check("t6_miss_early", bus.miss_cnt, 0);
    tick(1);
    check("t6_escape", bus.miss_cnt, 1);
    tick(70);
    check("t6_mid_show", $countones(bus.mole_led), 1);
    rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    tick(2);
    rst = 1'b0;
    tick(20);
    check_all_zero("t6_no_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
